// File: rtl/prom_copier_pkg.sv
// Shared types and default widths for the boot PROM copy engine and the boot PROM.
package prom_copier_pkg;

    localparam int unsigned PROM_AW = 9;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/prom_copier.sv
// Boot-time copy engine: reads N_WORDS words from the synchronous boot PROM,
// starting at PROM word 0, and writes them to main memory at DST_BASE onwards
// through a valid/ready port, keeping a running 32-bit checksum of accepted words.
module prom_copier #(
    parameter int unsigned N_WORDS  = 512,
    parameter int unsigned PROM_AW  = prom_copier_pkg::PROM_AW,
    parameter int unsigned DST_AW   = 22,
    parameter int unsigned DST_BASE = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    output logic                                prom_ce_o,
    output logic [PROM_AW-1:0]                  prom_adr_o,
    input  logic [prom_copier_pkg::DATA_W-1:0]  prom_data_i,
    output logic                                mem_wr_valid_o,
    input  logic                                mem_wr_ready_i,
    output logic [DST_AW-1:0]                   mem_wr_adr_o,
    output logic [prom_copier_pkg::DATA_W-1:0]  mem_wr_data_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [prom_copier_pkg::DATA_W-1:0]  checksum_o
);
    import prom_copier_pkg::*;

    localparam logic [PROM_AW-1:0] LastIdx = PROM_AW'(N_WORDS - 1);

    state_e              state_q, state_d;
    logic [PROM_AW-1:0]  idx_q, idx_d;
    logic [DST_AW-1:0]   mem_wr_adr_q, mem_wr_adr_d;
    logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [DST_AW-1:0]   dst_adr;

    // Destination address wraps modulo 2^DST_AW.
    assign dst_adr = DST_AW'(DST_BASE + 32'(idx_q));

    // State and datapath registers; reset returns to IDLE and drops any copy in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            mem_wr_adr_q  <= '0;
            mem_wr_data_q <= '0;
            checksum_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mem_wr_adr_q  <= mem_wr_adr_d;
            mem_wr_data_q <= mem_wr_data_d;
            checksum_q    <= checksum_d;
        end
    end

    // Next-state logic: one PROM read, one wait for registered data, then hold the write.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mem_wr_adr_d  = mem_wr_adr_q;
        mem_wr_data_d = mem_wr_data_q;
        checksum_d    = checksum_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = StRead;
                end
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                mem_wr_data_d = prom_data_i;
                mem_wr_adr_d  = dst_adr;
                state_d       = StWrite;
            end
            StWrite: begin
                if (mem_wr_ready_i) begin
                    checksum_d = checksum_q + mem_wr_data_q;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come straight from registers or a decode of the state register.
    always_comb begin
        prom_ce_o      = (state_q == StRead);
        prom_adr_o     = idx_q;
        mem_wr_valid_o = (state_q == StWrite);
        mem_wr_adr_o   = mem_wr_adr_q;
        mem_wr_data_o  = mem_wr_data_q;
        busy_o         = (state_q == StRead) || (state_q == StWait) || (state_q == StWrite);
        done_o         = (state_q == StDone);
        checksum_o     = checksum_q;
    end

endmodule

// File: tb/tb_prom_copier.sv
// Self-checking bench for prom_copier: two instances (basic and address-wrap setups),
// behavioural one-cycle-latency PROM models, and a write scoreboard per instance.
module tb_prom_copier;

    localparam int NW = 4;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, ready_a, ready_b;

    logic        prom_ce_a, prom_ce_b;
    logic [8:0]  prom_adr_a, prom_adr_b;
    logic [31:0] prom_data_a, prom_data_b;
    logic        mem_wr_valid_a, mem_wr_valid_b;
    logic [21:0] mem_wr_adr_a;
    logic [3:0]  mem_wr_adr_b;
    logic [31:0] mem_wr_data_a, mem_wr_data_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] checksum_a, checksum_b;

    logic [31:0] rom_a [512];
    logic [31:0] rom_b [512];

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    int t0_a, t0_b, done_cyc_a, done_cnt_a = 0, done_cnt_b = 0;
    int stall_left_a = 0;
    int cyc_a, cyc_b;
    bit act_a = 0, act_b = 0;
    logic [31:0] sum_a;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t e_a, e_b;
    int exp_adr_b [NW] = '{14, 15, 0, 1};

    prom_copier #(.N_WORDS(NW), .PROM_AW(9), .DST_AW(22), .DST_BASE(32'h100)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .prom_ce_o(prom_ce_a), .prom_adr_o(prom_adr_a), .prom_data_i(prom_data_a),
        .mem_wr_valid_o(mem_wr_valid_a), .mem_wr_ready_i(ready_a),
        .mem_wr_adr_o(mem_wr_adr_a), .mem_wr_data_o(mem_wr_data_a),
        .busy_o(busy_a), .done_o(done_a), .checksum_o(checksum_a)
    );

    prom_copier #(.N_WORDS(NW), .PROM_AW(9), .DST_AW(4), .DST_BASE(14)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .prom_ce_o(prom_ce_b), .prom_adr_o(prom_adr_b), .prom_data_i(prom_data_b),
        .mem_wr_valid_o(mem_wr_valid_b), .mem_wr_ready_i(ready_b),
        .mem_wr_adr_o(mem_wr_adr_b), .mem_wr_data_o(mem_wr_data_b),
        .busy_o(busy_b), .done_o(done_b), .checksum_o(checksum_b)
    );

    // PROM models: data registered one cycle after ce.
    always @(posedge clk) begin
        if (prom_ce_a) prom_data_a <= rom_a[prom_adr_a];
        if (prom_ce_b) prom_data_b <= rom_b[prom_adr_b];
        edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instance A: drives ready (with optional stall on word 1) and scores writes/done.
    always @(negedge clk) begin
        if (!rst && act_a) begin
            cyc_a = edge_n - t0_a;
            if (mem_wr_valid_a && stall_left_a > 0 && 32'(mem_wr_adr_a) == 32'h101) begin
                ready_a = 1'b0;
                stall_left_a--;
            end else begin
                ready_a = 1'b1;
            end
            if (cyc_a == 1) check("sum_clear", checksum_a, 32'h0);
            if (mem_wr_valid_a && !ready_a) begin
                check("stall_adr", 32'(mem_wr_adr_a), 32'h101);
                check("stall_data", mem_wr_data_a, rom_a[1]);
                check("stall_ce", 32'(prom_ce_a), 32'h0);
            end
            if (mem_wr_valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    check("extra_wr_a", 32'h1, 32'h0);
                end else begin
                    e_a = q_a.pop_front();
                    check("wr_adr_a", 32'(mem_wr_adr_a), e_a.adr);
                    check("wr_data_a", mem_wr_data_a, e_a.data);
                    check("wr_cyc_a", 32'(cyc_a), 32'(e_a.cyc));
                end
            end
            if (done_a) begin
                check("done_cyc_a", 32'(cyc_a), 32'(done_cyc_a));
                check("busy_at_done_a", 32'(busy_a), 32'h0);
                check("checksum_a", checksum_a, sum_a);
                check("left_a", 32'(q_a.size()), 32'h0);
                act_a = 0;
                done_cnt_a++;
            end
        end
    end

    // Instance B: ready tied high; scores wrapped addresses and the overflowing checksum.
    always @(negedge clk) begin
        if (!rst && act_b) begin
            cyc_b = edge_n - t0_b;
            if (mem_wr_valid_b) begin
                if (q_b.size() == 0) begin
                    check("extra_wr_b", 32'h1, 32'h0);
                end else begin
                    e_b = q_b.pop_front();
                    check("wr_adr_b", 32'(mem_wr_adr_b), e_b.adr);
                    check("wr_data_b", mem_wr_data_b, e_b.data);
                    check("wr_cyc_b", 32'(cyc_b), 32'(e_b.cyc));
                end
            end
            if (done_b) begin
                check("done_cyc_b", 32'(cyc_b), 32'd13);
                check("checksum_b", checksum_b, 32'h0000_0001);
                check("left_b", 32'(q_b.size()), 32'h0);
                act_b = 0;
                done_cnt_b++;
            end
        end
    end

    task automatic start_a_copy(input int stall_n);
        @(negedge clk);
        sum_a = 32'h0;
        for (int k = 0; k < NW; k++) begin
            q_a.push_back('{32'h100 + 32'(k), rom_a[k], 3 + 3 * k + ((k >= 1) ? stall_n : 0)});
            sum_a = sum_a + rom_a[k];
        end
        done_cyc_a   = 3 * NW + 1 + stall_n;
        stall_left_a = stall_n;
        start_a      = 1'b1;
        @(posedge clk);
        #1;
        t0_a    = edge_n - 1;
        act_a   = 1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int prev);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_a != prev) break;
        end
        check("done_seen_a", 32'(done_cnt_a - prev), 32'h1);
    endtask

    task automatic wait_cyc_a(input int c);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (edge_n - t0_a == c) break;
        end
    endtask

    // Extra start pulse sampled at the end of copy cycle c.
    task automatic pulse_a(input int c);
        wait_cyc_a(c);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, "_ce"}, 32'(prom_ce_a), 32'h0);
        check({tag, "_padr"}, 32'(prom_adr_a), 32'h0);
        check({tag, "_valid"}, 32'(mem_wr_valid_a), 32'h0);
        check({tag, "_wadr"}, 32'(mem_wr_adr_a), 32'h0);
        check({tag, "_wdata"}, mem_wr_data_a, 32'h0);
        check({tag, "_busy"}, 32'(busy_a), 32'h0);
        check({tag, "_done"}, 32'(done_a), 32'h0);
        check({tag, "_sum"}, checksum_a, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            rom_a[i] = 32'h0;
            rom_b[i] = 32'h0;
        end
        rom_a[0] = 32'h1111_1111; rom_a[1] = 32'h2222_2222;
        rom_a[2] = 32'h3333_3333; rom_a[3] = 32'h4444_4444;
        rom_b[0] = 32'hFFFF_FFFF; rom_b[1] = 32'h0000_0002;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;

        // Asynchronous reset mid-cycle, before any clock edge; start held high meanwhile.
        #2;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        #1;
        check_a_cleared("rst");
        check("rst_valid_b", 32'(mem_wr_valid_b), 32'h0);
        check("rst_sum_b", checksum_b, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ignored", 32'(busy_a), 32'h0);
        check("rst_start_ignored_ce", 32'(prom_ce_a), 32'h0);
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy_a), 32'h0);

        // Basic copy, ready held high.
        start_a_copy(0);
        wait_done_a(done_cnt_a);

        // Backpressure: five stalled cycles on word 1.
        start_a_copy(5);
        wait_done_a(done_cnt_a);

        // Start pulses in READ (cycle 4) and DONE (cycle 13) are ignored; restart right after.
        start_a_copy(0);
        fork
            pulse_a(4);
            pulse_a(13);
        join_none
        wait_done_a(done_cnt_a);
        start_a_copy(0);
        wait_done_a(done_cnt_a);

        // Reset during the WRITE of word 2, then a clean copy from word 0.
        start_a_copy(0);
        wait_cyc_a(8);
        @(posedge clk);
        #2;
        check("mid_valid", 32'(mem_wr_valid_a), 32'h1);
        check("mid_adr", 32'(mem_wr_adr_a), 32'h102);
        rst = 1'b1;
        #1;
        check_a_cleared("midrst");
        q_a.delete();
        act_a = 0;
        @(negedge clk);
        rst = 1'b0;
        ready_a = 1'b1;
        start_a_copy(0);
        wait_done_a(done_cnt_a);

        // Address wrap and checksum overflow on instance B.
        @(negedge clk);
        for (int k = 0; k < NW; k++) q_b.push_back('{32'(exp_adr_b[k]), rom_b[k], 3 + 3 * k});
        start_b = 1'b1;
        @(posedge clk);
        #1;
        t0_b    = edge_n - 1;
        act_b   = 1;
        start_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_b != 0) break;
        end
        check("done_seen_b", 32'(done_cnt_b), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
